mem_stage_lsu: RTL
==================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 The block SHALL have one parameter: DATA_WIDTH, default 32, the datapath and bus data width.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-003 Ports SHALL be as follows:
- clk  in  1  clock
- rst  in  1  reset
- RegWriteM  in  1  register write enable from EX/MEM
- ResultSrcM  in  2  result select; 01 = load
- MemWriteM  in  1  store request
- funct3M  in  3  access size and sign
- ALUResultM  in  DATA_WIDTH  byte address
- WriteDataM  in  DATA_WIDTH  store data
- RdM  in  5  destination register
- PCPlus4M  in  DATA_WIDTH  link value
- StallM  out  1  MEM incomplete; upstream holds
- BusReq  out  1  bus request
- BusWe  out  1  1 = write
- BusAddr  out  DATA_WIDTH  word-aligned address
- BusWData  out  DATA_WIDTH  lane-replicated store data
- BusBe  out  4  byte enables
- BusGnt  in  1  request accepted
- BusRValid  in  1  read data valid
- BusRData  in  DATA_WIDTH  read data
- RegWriteW, ResultSrcW, RdW, ALUResultW, PCPlus4W, ReadDataW  out  MEM/WB register
- MisalignM  out  1  misaligned access (macro only)

Function
REQ-004 A memory op SHALL be MemWriteM=1 (store) or ResultSrcM=01 (load); all other inputs SHALL be pass-through.
REQ-005 The FSM SHALL have states IDLE, REQ and WAIT_R.
REQ-006 In IDLE or REQ with an op pending, BusReq SHALL be driven combinationally, with BusAddr = {ALUResultM[31:2],2'b00} and BusWe = MemWriteM.
REQ-007 A store SHALL complete in the cycle BusGnt=1, giving zero stall if the grant arrives the same cycle. A store without a grant SHALL go from IDLE to REQ.
REQ-008 A load granted in IDLE or REQ SHALL go to WAIT_R. It SHALL complete in the cycle BusRValid=1 in WAIT_R and then return to IDLE, so minimum load latency is 1 stall cycle.
REQ-009 StallM SHALL be 1 while an op is pending and not completing that cycle, and 0 otherwise.
REQ-010 BusRValid outside WAIT_R SHALL be ignored.
REQ-011 Byte enables SHALL be:
- SB: 0001 << addr[1:0]
- SH: 0011 << {addr[1],1'b0}
- SW: 1111
BusWData SHALL be the byte or halfword replicated across all lanes.
REQ-012 Load extraction SHALL select the lane by addr[1:0]:
- LB / LH: sign-extended
- LBU / LHU: zero-extended
- LW: unmodified
REQ-013 The MEM/WB register SHALL update on each edge with StallM=0.
REQ-014 On each edge with StallM=1, the MEM/WB register SHALL load a bubble: RegWriteW=0 and RdW=0.
REQ-015 ReadDataW SHALL carry extracted load data on the completion edge.
REQ-016 Undefined funct3 for a memory op SHALL be treated as word size.

Reset
REQ-017 Asserting rst SHALL, asynchronously:
- put the FSM in IDLE
- clear all W outputs and MisalignM
- force BusReq=0 and StallM=0
REQ-018 Reset during REQ or WAIT_R SHALL abandon the access; a BusRValid arriving after reset SHALL be ignored.

Configuration
REQ-019 With MISALIGN_TRAP_EN defined:
- an LH/SH/LHU access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL assert MisalignM for that cycle
- that access SHALL not assert BusReq
- it SHALL complete with no stall
- it SHALL write back a bubble
REQ-020 Without MISALIGN_TRAP_EN:
- MisalignM SHALL be tied 0
- misaligned accesses SHALL be issued using the REQ-011 enables
- bytes beyond the word boundary SHALL be dropped

Structure
REQ-021 The package rv_pkg SHALL hold the funct3 load/store encodings, the ResultSrc encodings and the lsu_state_t enum.
REQ-022 The combinational byte-lane, replication and extension logic SHALL be a sub-module named lsu_align.

Verification
REQ-023 The bench SHALL cover:
- SW, addr 0x100, data 0xDEADBEEF, BusGnt same cycle -> BusBe=1111, BusAddr=0x100, StallM=0 throughout.
- LB, addr 0x203, BusGnt after 2 cycles, BusRValid 1 cycle later, BusRData=0x80112233 -> StallM high 3 cycles, ReadDataW=0xFFFFFF80, RegWriteW=1 one edge later.
- LHU, addr 0x202, BusRData=0x8001ABCD -> ReadDataW=0x00008001; SB, addr 0x101, data 0x5A -> BusBe=0010, BusWData=0x5A5A5A5A.
- rst asserted in WAIT_R, then BusRValid=1 -> FSM in IDLE, BusReq=0, RegWriteW=0, no writeback.
- MISALIGN_TRAP_EN, LW, addr 0x102 -> MisalignM=1, BusReq=0, StallM=0, RegWriteW=0.
- Non-memory op with RegWriteM=1, RdM=5, ALUResultM=7 -> RegWriteW=1, RdW=5, ALUResultW=7 one edge later.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 load/store encodings, result-select codes and LSU state type.
package rv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_t;

  // Undefined size encodings fall through to word.
  function automatic acc_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane enables, store-data replication and load-data extraction/extension.
module lsu_align
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata_rep,
  output logic [DATA_WIDTH-1:0] rdata_ext
);

  acc_size_t             sz;
  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    sz        = f3_size(funct3);
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    // Shifting by the full byte offset drops any bytes past the word boundary.
    shifted   = rdata >> {addr_lo, 3'b000};
    case (sz)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {(DATA_WIDTH/8){wdata[7:0]}};
        rdata_ext = funct3[2] ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                              : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {(DATA_WIDTH/16){wdata[15:0]}};
        rdata_ext = funct3[2] ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                              : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage load/store unit with bus handshake FSM and MEM/WB register.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_stage_lsu
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic                  StallM,
  output logic                  BusReq,
  output logic                  BusWe,
  output logic [DATA_WIDTH-1:0] BusAddr,
  output logic [DATA_WIDTH-1:0] BusWData,
  output logic [3:0]            BusBe,
  input  logic                  BusGnt,
  input  logic                  BusRValid,
  input  logic [DATA_WIDTH-1:0] BusRData,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [4:0]            RdW,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] PCPlus4W,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic                  MisalignM
);

  lsu_state_t            state_q, state_d;
  logic                  regwrite_q, regwrite_d;
  logic [1:0]            resultsrc_q, resultsrc_d;
  logic [4:0]            rd_q, rd_d;
  logic [DATA_WIDTH-1:0] aluresult_q, aluresult_d;
  logic [DATA_WIDTH-1:0] pcplus4_q, pcplus4_d;
  logic [DATA_WIDTH-1:0] readdata_q, readdata_d;

  logic                  is_store, mem_op, misalign, op_pend, complete;
  logic [DATA_WIDTH-1:0] rdata_ext;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3    (funct3M),
    .addr_lo   (ALUResultM[1:0]),
    .wdata     (WriteDataM),
    .rdata     (BusRData),
    .be        (BusBe),
    .wdata_rep (BusWData),
    .rdata_ext (rdata_ext)
  );

  assign is_store = MemWriteM;
  assign mem_op   = MemWriteM | (ResultSrcM == RES_LOAD);

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (mem_op) begin
      case (f3_size(funct3M))
        SZ_B:    misalign = 1'b0;
        SZ_H:    misalign = ALUResultM[0];
        default: misalign = (ALUResultM[1:0] != 2'b00);
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign MisalignM = misalign & ~rst;
  assign op_pend   = mem_op & ~misalign;
  assign BusAddr   = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
  assign BusWe     = MemWriteM;
  assign BusReq    = op_pend & (state_q != WAIT_R) & ~rst;

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    case (state_q)
      IDLE, REQ: begin
        if (op_pend) begin
          if (BusGnt) begin
            complete = is_store;
            state_d  = is_store ? IDLE : WAIT_R;
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_R: begin
        if (BusRValid) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign StallM = op_pend & ~complete & ~rst;

  // A stalled or trapped access leaves a bubble in WB; payload fields still follow M.
  always_comb begin
    regwrite_d  = RegWriteM & ~StallM & ~misalign;
    rd_d        = (StallM | misalign) ? 5'd0 : RdM;
    resultsrc_d = ResultSrcM;
    aluresult_d = ALUResultM;
    pcplus4_d   = PCPlus4M;
    readdata_d  = rdata_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      regwrite_q  <= 1'b0;
      resultsrc_q <= '0;
      rd_q        <= '0;
      aluresult_q <= '0;
      pcplus4_q   <= '0;
      readdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      regwrite_q  <= regwrite_d;
      resultsrc_q <= resultsrc_d;
      rd_q        <= rd_d;
      aluresult_q <= aluresult_d;
      pcplus4_q   <= pcplus4_d;
      readdata_q  <= readdata_d;
    end
  end

  assign RegWriteW  = regwrite_q;
  assign ResultSrcW = resultsrc_q;
  assign RdW        = rd_q;
  assign ALUResultW = aluresult_q;
  assign PCPlus4W   = pcplus4_q;
  assign ReadDataW  = readdata_q;

endmodule
